mem_stage_unit: RTL

//   Consumer side of the EX/MEM pipeline register: takes the latched EX/MEM fields, runs the

---
 rtl/mem_stage_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_unit.sv
// MEM stage of the pipeline: consumes the EX/MEM register, runs the data-memory
// access over a req/ack handshake, resolves branch/jump redirects, drives the
// upstream load enable (IRWr) and flush (EX2MEMRst), and holds the MEM/WB register.
module mem_stage_unit #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM register fields
  input  logic [29:0] PC,
  input  logic [4:0]  RegDst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemWrite,
  input  logic        ZERO,
  input  logic        cJump,
  input  logic        cBranch,
  input  logic        cMemRead,
  input  logic        cMemtoReg,
  input  logic        cMemWrite,
  input  logic        cRegWrite,
  // data-memory handshake
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  // pipeline control
  output logic        IRWr,
  output logic        EX2MEMRst,
  output logic        PCSrc,
  output logic [29:0] NPC,
  // MEM/WB register
  output logic [4:0]  wb_RegDst,
  output logic [31:0] wb_Result,
  output logic        wb_cRegWrite,
  output logic        err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // A zero timeout disables the abort path; the counter then just free-runs.
  localparam bit          TO_EN   = (ACK_TIMEOUT != 0);
  localparam int unsigned TO_LAST = TO_EN ? (ACK_TIMEOUT - 1) : 0;
  localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);

  state_t state_q, state_d;

  logic            dm_req_q,   dm_req_d;
  logic            dm_we_q,    dm_we_d;
  logic [29:0]     dm_addr_q,  dm_addr_d;
  logic [31:0]     dm_wdata_q, dm_wdata_d;
  logic [TO_W-1:0] count_q,    count_d;
  logic [4:0]      wb_rd_q,    wb_rd_d;
  logic [31:0]     wb_res_q,   wb_res_d;
  logic            wb_we_q,    wb_we_d;
  logic            err_q,      err_d;

  logic memop;
  logic timeout_hit;
  logic irwr;
  logic capture_alu;
  logic start_acc;
  logic mem_done;
  logic redirect;

  // Byte-offset bits of the address are not used for word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ALUResult[1:0];

  assign memop       = cMemRead | cMemWrite;
  assign timeout_hit = TO_EN && (state_q == ACCESS) && !dm_ack && (count_q == TO_LAST_V);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on a memory op, return on ack or timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (memop) state_d = ACCESS;
      ACCESS:  if (dm_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pipeline enable and the per-cycle action strobes
  always_comb begin
    irwr        = 1'b0;
    capture_alu = 1'b0;
    start_acc   = 1'b0;
    mem_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          start_acc = 1'b1;
        end else begin
          irwr        = 1'b1;
          capture_alu = 1'b1;
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          irwr     = 1'b1;
          mem_done = 1'b1;
        end else if (timeout_hit) begin
          irwr = 1'b1;
        end
      end
      default: begin
        irwr = 1'b0;
      end
    endcase
  end

  // Redirect is only honoured when the instruction actually leaves the stage.
  assign redirect  = irwr & (cJump | (cBranch & ZERO));
  assign IRWr      = irwr;
  assign PCSrc     = redirect;
  assign EX2MEMRst = redirect;
  assign NPC       = PC;

  // Datapath next-state: request latch, timeout counter, MEM/WB capture, error flag
  always_comb begin
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    count_d    = count_q;
    wb_rd_d    = wb_rd_q;
    wb_res_d   = wb_res_q;
    // Any edge that does not retire an instruction inserts a bubble.
    wb_we_d    = 1'b0;
    err_d      = err_q | timeout_hit;

    if (capture_alu) begin
      wb_rd_d  = RegDst;
      wb_res_d = ALUResult;
      wb_we_d  = cRegWrite;
    end

    if (start_acc) begin
      dm_req_d   = 1'b1;
      // Write wins when both read and write are flagged.
      dm_we_d    = cMemWrite;
      dm_addr_d  = ALUResult[31:2];
      dm_wdata_d = MemWrite;
      count_d    = '0;
    end

    if (state_q == ACCESS) begin
      if (mem_done) begin
        dm_req_d = 1'b0;
        wb_rd_d  = RegDst;
        wb_res_d = cMemtoReg ? dm_rdata : ALUResult;
        wb_we_d  = cRegWrite;
        count_d  = '0;
      end else if (timeout_hit) begin
        // Abandoned access: write-back keeps its old data and writes nothing.
        dm_req_d = 1'b0;
        count_d  = '0;
      end else begin
        count_d = count_q + TO_W'(1);
      end
    end
  end

  // Datapath registers; async reset also drops dm_req immediately mid-access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      count_q    <= '0;
      wb_rd_q    <= '0;
      wb_res_q   <= '0;
      wb_we_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      count_q    <= count_d;
      wb_rd_q    <= wb_rd_d;
      wb_res_q   <= wb_res_d;
      wb_we_q    <= wb_we_d;
      err_q      <= err_d;
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign wb_RegDst    = wb_rd_q;
  assign wb_Result    = wb_res_q;
  assign wb_cRegWrite = wb_we_q;
  assign err          = err_q;

endmodule
